priority_grant_ctrl: RTL and testbench

Downstream stage of the 4-input priority encoder. It takes the registered encoded index and `valid` and turns them into a one-hot grant to the winning requester. The grant is held until the requester signals completion or a timeout expires, then released through a one-cycle guard gap. All outputs are registered.

---
 rtl/priority_grant_ctrl.sv | 143 ++++++++++++++
 tb/tb_priority_grant_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/priority_grant_ctrl.sv
// One-hot grant controller behind the 4-input priority encoder: capture, hold, guard.
// Optional per-channel grant statistics are enabled with `define GRANT_STATS_EN.
module priority_grant_ctrl #(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] Y,
    input  logic       valid,
    input  logic       done,
    output logic [3:0] grant,
    output logic       busy,
    output logic       timeout,
    output logic [1:0] owner
`ifdef GRANT_STATS_EN
    ,
    output logic [15:0] stat_cnt,
    output logic [3:0]  stat_to
`endif
);

    // state  | meaning
    // IDLE   | waiting for valid; captures Y into owner
    // GRANT  | owner holds the grant; hold counter runs
    // GUARD  | one-cycle gap after release; inputs ignored
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         owner_q, owner_d;
    logic               to_exit_q, to_exit_d;
    logic [3:0]         grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;
    logic               capture;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        to_exit_d = 1'b0;
        capture   = 1'b0;

        // Outputs are a registered image of the current state, one cycle behind it.
        grant_d   = (state_q == ST_GRANT) ? (4'b0001 << owner_q) : 4'b0000;
        busy_d    = (state_q != ST_IDLE);
        timeout_d = (state_q == ST_GUARD) && to_exit_q;

        unique case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    state_d = ST_GRANT;
                    owner_d = Y;
                    cnt_d   = '0;
                    capture = 1'b1;
                end
            end
            ST_GRANT: begin
                if (done) begin
                    state_d = ST_GUARD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_GUARD;
                    to_exit_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GUARD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            owner_q   <= 2'b00;
            to_exit_q <= 1'b0;
            grant_q   <= 4'b0000;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            to_exit_q <= to_exit_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;
    assign owner   = owner_q;

`ifdef GRANT_STATS_EN
    logic [15:0] stat_cnt_q, stat_cnt_d;
    logic [3:0]  stat_to_q, stat_to_d;
    logic [3:0]  cap_lsb;
    logic [3:0]  cap_cnt;

    assign cap_lsb = {Y, 2'b00};
    assign cap_cnt = stat_cnt_q[cap_lsb +: 4];

    always_comb begin
        stat_cnt_d = stat_cnt_q;
        stat_to_d  = stat_to_q;
        if (capture && (cap_cnt != 4'hF)) begin
            stat_cnt_d[cap_lsb +: 4] = cap_cnt + 4'd1;
        end
        if (to_exit_d) begin
            stat_to_d[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cnt_q <= '0;
            stat_to_q  <= '0;
        end else begin
            stat_cnt_q <= stat_cnt_d;
            stat_to_q  <= stat_to_d;
        end
    end

    assign stat_cnt = stat_cnt_q;
    assign stat_to  = stat_to_q;
`endif

endmodule

// File: tb/tb_priority_grant_ctrl.sv
// Self-checking bench for priority_grant_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a phase/age model of the grant protocol.
module tb_priority_grant_ctrl;

    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] Y;
    logic       valid;
    logic       done;
    logic [3:0] grant;
    logic       busy;
    logic       timeout;
    logic [1:0] owner;
`ifdef GRANT_STATS_EN
    logic [15:0] stat_cnt;
    logic [3:0]  stat_to;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    priority_grant_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .Y       (Y),
        .valid   (valid),
        .done    (done),
        .grant   (grant),
        .busy    (busy),
        .timeout (timeout),
        .owner   (owner)
`ifdef GRANT_STATS_EN
        ,
        .stat_cnt(stat_cnt),
        .stat_to (stat_to)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_age is the number of cycles the current grant has lasted (-1 = no grant),
    // m_gap marks the single guard cycle. Visible outputs trail the protocol by one edge.
    int         m_age   = -1;
    bit         m_gap   = 1'b0;
    bit         m_to    = 1'b0;
    logic [1:0] m_owner = 2'b00;
    bit         m_ready = 1'b0;
    logic [3:0] e_grant;
    logic       e_busy;
    logic       e_to;
    int         st_cnt[4];
    logic [3:0] st_to;

    always @(posedge clk) begin
        if (rst) begin
            m_age = -1; m_gap = 1'b0; m_to = 1'b0; m_owner = 2'b00;
            e_grant = 4'b0000; e_busy = 1'b0; e_to = 1'b0;
            for (int i = 0; i < 4; i++) st_cnt[i] = 0;
            st_to = 4'b0000;
            m_ready = 1'b1;
        end else begin
            e_grant = (m_age >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            e_busy  = (m_age >= 0) || m_gap;
            e_to    = m_gap && m_to;
            if (m_gap) begin
                m_gap = 1'b0;
                m_to  = 1'b0;
            end else if (m_age >= 0) begin
                if (done) begin
                    m_age = -1; m_gap = 1'b1; m_to = 1'b0;
                end else if (m_age == TIMEOUT - 1) begin
                    m_age = -1; m_gap = 1'b1; m_to = 1'b1;
                    st_to[m_owner] = 1'b1;
                end else begin
                    m_age++;
                end
            end else if (valid) begin
                m_owner = Y;
                m_age   = 0;
                if (st_cnt[m_owner] < 15) st_cnt[m_owner]++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            chk("grant", 32'(grant), 32'(e_grant));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("timeout", 32'(timeout), 32'(e_to));
            chk("owner", 32'(owner), 32'(m_owner));
            chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
`ifdef GRANT_STATS_EN
            for (int i = 0; i < 4; i++)
                chk($sformatf("stat_cnt%0d", i), 32'(stat_cnt[4*i +: 4]), 32'(st_cnt[i]));
            chk("stat_to", 32'(stat_to), 32'(st_to));
`endif
        end
    end

    // Issue one request for y, then observe 14 cycles starting the cycle after the capture edge.
    task automatic req(input logic [1:0] y, input int done_at, input int rst_at, input bit y0_hold,
                       output int g_cyc, output int to_cnt, output int busy_cyc,
                       output logic [3:0] g_k2, output logic [1:0] own_k2, output logic b_k2,
                       output bit saw1);
        g_cyc = 0; to_cnt = 0; busy_cyc = 0; saw1 = 1'b0;
        g_k2 = 4'hx; own_k2 = 2'bxx; b_k2 = 1'bx;
        @(negedge clk);
        valid = 1'b1; Y = y;
        @(negedge clk);
        valid = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) @(negedge clk);
            if (grant != 4'b0000) g_cyc++;
            if (timeout) to_cnt++;
            if (busy) busy_cyc++;
            if (k == 2) begin g_k2 = grant; own_k2 = owner; b_k2 = busy; end
            if (grant == 4'b0001) saw1 = 1'b1;
            done = (k == done_at);
            rst  = (k == rst_at);
            if (y0_hold && k >= 1 && k < 5) begin
                valid = 1'b1; Y = 2'd0;
            end else begin
                valid = 1'b0;
            end
        end
        done = 1'b0; rst = 1'b0; valid = 1'b0;
    endtask

    int         g_cyc, to_cnt, busy_cyc;
    logic [3:0] g_k2;
    logic [1:0] own_k2;
    logic       b_k2;
    bit         saw1;

    initial begin
        rst = 1'b1; valid = 1'b1; Y = 2'd2; done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        rst = 1'b0; valid = 1'b0;
        repeat (2) @(negedge clk);

        req(2'd1, 2, -1, 1'b0, g_cyc, to_cnt, busy_cyc, g_k2, own_k2, b_k2, saw1);
        chk("normal_grant_cycles", 32'(g_cyc), 32'd3);
        chk("normal_grant_value", 32'(g_k2), 32'h2);
        chk("normal_busy_cycles", 32'(busy_cyc), 32'd4);
        chk("normal_timeout", 32'(to_cnt), 32'd0);
        chk("normal_owner", 32'(owner), 32'd1);

        req(2'd3, -1, -1, 1'b0, g_cyc, to_cnt, busy_cyc, g_k2, own_k2, b_k2, saw1);
        chk("to_grant_cycles", 32'(g_cyc), 32'd8);
        chk("to_grant_value", 32'(g_k2), 32'h8);
        chk("to_pulses", 32'(to_cnt), 32'd1);
        chk("to_busy_cycles", 32'(busy_cyc), 32'd9);

        req(2'd2, 7, -1, 1'b0, g_cyc, to_cnt, busy_cyc, g_k2, own_k2, b_k2, saw1);
        chk("simul_grant_cycles", 32'(g_cyc), 32'd8);
        chk("simul_timeout", 32'(to_cnt), 32'd0);

        req(2'd3, 1, -1, 1'b1, g_cyc, to_cnt, busy_cyc, g_k2, own_k2, b_k2, saw1);
        chk("ign_owner_held", 32'(own_k2), 32'd3);
        chk("ign_grant_held", 32'(g_k2), 32'h8);
        chk("ign_next_capture_0001", 32'(saw1), 32'd1);
        repeat (12) @(negedge clk);
`ifdef GRANT_STATS_EN
        chk("stats_to_flags", 32'(stat_to), 32'h9);
        chk("stats_ch3_count", 32'(stat_cnt[15:12]), 32'd2);
`endif

        req(2'd2, -1, 1, 1'b0, g_cyc, to_cnt, busy_cyc, g_k2, own_k2, b_k2, saw1);
        chk("midrst_grant", 32'(g_k2), 32'h0);
        chk("midrst_busy", 32'(b_k2), 32'h0);
        chk("midrst_grant_cycles", 32'(g_cyc), 32'd1);
`ifdef GRANT_STATS_EN
        chk("midrst_stat_ch2", 32'(stat_cnt[11:8]), 32'd0);
`endif

        for (int blk = 0; blk < 6; blk++) begin
            int done_pct;
            case (blk)
                0: done_pct = 0;
                1: done_pct = 5;
                2: done_pct = 25;
                3: done_pct = 50;
                4: done_pct = 90;
                default: done_pct = 15;
            endcase
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                rst   = ($urandom_range(0, 149) == 0);
                valid = ($urandom_range(0, 2) != 0);
                Y     = 2'($urandom_range(0, 3));
                done  = ($urandom_range(0, 99) < done_pct);
            end
        end
        @(negedge clk);
        rst = 1'b0; valid = 1'b0; done = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
